// File: rtl/button_debounce_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Width needed to hold values 0..max_count (never narrower than one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_debounce_multi_channel.sv
// One button channel: input synchroniser, debounce FSM, level, press/release
// strobes and a one-shot long-press strobe.
module debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int HOLD_CYCLES     = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic BI,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic HOLD
);

  localparam int CW = cnt_width((DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
  localparam bit            SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;
  logic                   s;
  btn_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   level_d, press_d, release_d, hold_d;

  assign pressed = BI ^ (ACTIVE_LOW != 0);
  assign s       = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (SINGLE) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          if (SINGLE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (state_d == PRESSED) && ((state_q == IDLE) || (state_q == PRESS_WAIT));
    release_d = (state_d == IDLE) && ((state_q == PRESSED) || (state_q == RELEASE_WAIT));
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;
    // A bounce back from RELEASE_WAIT keeps the hold count running.
    if (!level_d || press_d) begin
      hold_cnt_d = '0;
    end else if ((HOLD_CYCLES != 0) && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      hold_d     = (hold_cnt_d == HOLD_MAX);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      LEVEL      <= 1'b0;
      PRESS      <= 1'b0;
      RELEASE    <= 1'b0;
      HOLD       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pressed};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      LEVEL      <= level_d;
      PRESS      <= press_d;
      RELEASE    <= release_d;
      HOLD       <= hold_d;
    end
  end

endmodule

// File: rtl/button_debounce_multi.sv
// Multi-channel button conditioner: N_CH independent debounce channels.
module button_debounce_multi
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int HOLD_CYCLES     = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BI,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] HOLD
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .BI     (BI[i]),
      .LEVEL  (LEVEL[i]),
      .PRESS  (PRESS[i]),
      .RELEASE(RELEASE[i]),
      .HOLD   (HOLD[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: timestamped expectations are queued
// as stimulus is applied and compared at the falling edge of the matching cycle.
module tb_button_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bi_a, lvl_a, prs_a, rel_a, hld_a;
  logic [3:0] bi_b, lvl_b, prs_b, rel_b, hld_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int t;

  typedef struct {
    int          cyc;
    bit          id;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Active-high inputs, long-press after 8 cycles.
  button_debounce_multi #(.HOLD_CYCLES(8)) dut_a (
    .CLK(clk), .RST(rst), .BI(bi_a),
    .LEVEL(lvl_a), .PRESS(prs_a), .RELEASE(rel_a), .HOLD(hld_a)
  );

  // Active-low inputs, long-press disabled.
  button_debounce_multi #(.ACTIVE_LOW(1)) dut_b (
    .CLK(clk), .RST(rst), .BI(bi_b),
    .LEVEL(lvl_b), .PRESS(prs_b), .RELEASE(rel_b), .HOLD(hld_b)
  );

  function automatic logic [15:0] v(input logic [3:0] l, input logic [3:0] p,
                                    input logic [3:0] r, input logic [3:0] h);
    return {l, p, r, h};
  endfunction

  task automatic exp_range(input bit id, input string tag, input int c0, input int c1,
                           input logic [15:0] e);
    for (int c = c0; c <= c1; c++) sb.push_back('{c, id, e, tag});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    logic [15:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs = sb[i].id ? {lvl_b, prs_b, rel_b, hld_b} : {lvl_a, prs_a, rel_a, hld_a};
        n_cmp++;
        assert (obs === sb[i].exp)
        else begin
          n_bad++;
          $error("FAIL %s dut=%0d cyc=%0d observed{L,P,R,H}=%h expected=%h",
                 sb[i].tag, sb[i].id, cyc, obs, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    bi_a = '0;
    bi_b = '1;
    exp_range(0, "rst_a", 1, 3, '0);
    exp_range(1, "rst_b", 1, 3, '0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single press on ch0 with long-press strobe, then release.
    t = cyc;
    bi_a = 4'b0001;
    exp_range(0, "s1_wait",    t + 1,  t + 4,  '0);
    exp_range(0, "s1_press",   t + 5,  t + 5,  v(4'h1, 4'h1, 4'h0, 4'h0));
    exp_range(0, "s1_level",   t + 6,  t + 12, v(4'h1, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s1_hold",    t + 13, t + 13, v(4'h1, 4'h0, 4'h0, 4'h1));
    exp_range(0, "s1_nohold",  t + 14, t + 21, v(4'h1, 4'h0, 4'h0, 4'h0));
    exp_range(1, "s1_b_idle",  t + 1,  t + 21, '0);
    tick(21);
    bi_a = 4'b0000;
    exp_range(0, "s1_rwait",   t + 22, t + 25, v(4'h1, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s1_release", t + 26, t + 26, v(4'h0, 4'h0, 4'h1, 4'h0));
    exp_range(0, "s1_idle",    t + 27, t + 30, '0);
    tick(10);

    // Two-cycle glitch on ch1 must be rejected.
    t = cyc;
    bi_a = 4'b0010;
    exp_range(0, "s2_glitch", t + 1, t + 10, '0);
    tick(2);
    bi_a = 4'b0000;
    tick(10);

    // ch2 pressed; a one-cycle low during release is ignored and hold timing continues.
    t = cyc;
    bi_a = 4'b0100;
    exp_range(0, "s3_wait",    t + 1,  t + 4,  '0);
    exp_range(0, "s3_press",   t + 5,  t + 5,  v(4'h4, 4'h4, 4'h0, 4'h0));
    exp_range(0, "s3_level",   t + 6,  t + 12, v(4'h4, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s3_hold",    t + 13, t + 13, v(4'h4, 4'h0, 4'h0, 4'h4));
    exp_range(0, "s3_bounce",  t + 14, t + 15, v(4'h4, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s3_release", t + 16, t + 16, v(4'h0, 4'h0, 4'h4, 4'h0));
    exp_range(0, "s3_idle",    t + 17, t + 20, '0);
    tick(9);
    bi_a = 4'b0000;
    tick(1);
    bi_a = 4'b0100;
    tick(1);
    bi_a = 4'b0000;
    tick(10);

    // Active-low instance: ch3 pulled low then released.
    t = cyc;
    bi_b = 4'b0111;
    exp_range(1, "s4_wait",    t + 1,  t + 4,  '0);
    exp_range(1, "s4_press",   t + 5,  t + 5,  v(4'h8, 4'h8, 4'h0, 4'h0));
    exp_range(1, "s4_level",   t + 6,  t + 12, v(4'h8, 4'h0, 4'h0, 4'h0));
    exp_range(1, "s4_release", t + 13, t + 13, v(4'h0, 4'h0, 4'h8, 4'h0));
    exp_range(1, "s4_idle",    t + 14, t + 16, '0);
    exp_range(0, "s4_a_idle",  t + 1,  t + 16, '0);
    tick(8);
    bi_b = 4'b1111;
    tick(9);

    // Reset while ch0 is pressed; button stays held through deassertion.
    t = cyc;
    bi_a = 4'b0001;
    exp_range(0, "s5_wait",  t + 1, t + 4, '0);
    exp_range(0, "s5_press", t + 5, t + 5, v(4'h1, 4'h1, 4'h0, 4'h0));
    exp_range(0, "s5_level", t + 6, t + 7, v(4'h1, 4'h0, 4'h0, 4'h0));
    tick(7);
    rst = 1'b1;
    exp_range(0, "s5_rst_a", t + 8, t + 10, '0);
    exp_range(1, "s5_rst_b", t + 8, t + 10, '0);
    tick(3);
    rst = 1'b0;
    exp_range(0, "s5_rewait",  t + 11, t + 14, '0);
    exp_range(0, "s5_repress", t + 15, t + 15, v(4'h1, 4'h1, 4'h0, 4'h0));
    exp_range(0, "s5_relevel", t + 16, t + 20, v(4'h1, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s5_release", t + 21, t + 21, v(4'h0, 4'h0, 4'h1, 4'h0));
    exp_range(0, "s5_idle",    t + 22, t + 24, '0);
    tick(6);
    bi_a = 4'b0000;
    tick(9);

    // All channels pressed together, released staggered.
    t = cyc;
    bi_a = 4'b1111;
    exp_range(0, "s6_wait",   t + 1,  t + 4,  '0);
    exp_range(0, "s6_press",  t + 5,  t + 5,  v(4'hF, 4'hF, 4'h0, 4'h0));
    exp_range(0, "s6_level",  t + 6,  t + 11, v(4'hF, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s6_rel0",   t + 12, t + 12, v(4'hE, 4'h0, 4'h1, 4'h0));
    exp_range(0, "s6_hold",   t + 13, t + 13, v(4'hE, 4'h0, 4'h0, 4'hE));
    exp_range(0, "s6_rel1",   t + 14, t + 14, v(4'hC, 4'h0, 4'h2, 4'h0));
    exp_range(0, "s6_lvl23",  t + 15, t + 15, v(4'hC, 4'h0, 4'h0, 4'h0));
    exp_range(0, "s6_rel23",  t + 16, t + 16, v(4'h0, 4'h0, 4'hC, 4'h0));
    exp_range(0, "s6_idle",   t + 17, t + 19, '0);
    tick(7);
    bi_a = 4'b1110;
    tick(2);
    bi_a = 4'b1100;
    tick(2);
    bi_a = 4'b0000;
    tick(10);

    tick(3);
    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_bad++;
      $error("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
